ram_access_arbiter: RTL

//  Sequences every access to the shared 32x32 single-port RAM and shares it between two requesters:
//  the Manchester Baby core (port A) and the SPI RAM interface (port B).

---
 rtl/ram_access_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/ram_access_arbiter.sv
// Shared single-port RAM sequencer: arbitrates the Baby core (port A) and the SPI interface (port B)
// through a fixed IDLE -> ISSUE -> CAPTURE -> DONE access cycle with req/ack handshakes.
module ram_access_arbiter #(
    parameter int unsigned ADDR_W           = 5,
    parameter int unsigned DATA_W           = 32,
    parameter bit          SPI_ONLY_ON_HALT = 1'b1
) (
    input  logic              sys_clock_i,
    input  logic              rst_i,
    input  logic              baby_halt_i,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_ack_o,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_ack_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              busy_o,
    output logic              grant_b_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_t;

    state_t            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant_b_q;
    logic              a_ack_q;
    logic              b_ack_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    logic a_elig;
    logic b_elig;
    logic pick_b;

    // On a tie the port that did not own the previous access wins.
    always_comb begin
        a_elig = a_req_i;
        b_elig = b_req_i && (baby_halt_i || !SPI_ONLY_ON_HALT);
        pick_b = b_elig && (!a_elig || !grant_b_q);
    end

    always_ff @(posedge sys_clock_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            grant_b_q <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (a_elig || b_elig) begin
                        grant_b_q <= pick_b;
                        we_q      <= pick_b ? b_we_i    : a_we_i;
                        addr_q    <= pick_b ? b_addr_i  : a_addr_i;
                        wdata_q   <= pick_b ? b_wdata_i : a_wdata_i;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    if (!we_q) begin
                        if (grant_b_q) b_rdata_q <= ram_rdata_i;
                        else           a_rdata_q <= ram_rdata_i;
                    end
                    if (grant_b_q) b_ack_q <= 1'b1;
                    else           a_ack_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Strobe decodes straight from the state register; gating with rst_i blocks a commit in a reset cycle.
    assign ram_en_o    = (state_q == ISSUE) && !rst_i;
    assign ram_we_o    = ram_en_o && we_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign a_ack_o     = a_ack_q;
    assign b_ack_o     = b_ack_q;
    assign a_rdata_o   = a_rdata_q;
    assign b_rdata_o   = b_rdata_q;
    assign busy_o      = (state_q != IDLE);
    assign grant_b_o   = grant_b_q;

endmodule
